youssefland_button_scheduler: RTL and testbench
===============================================

Name: youssefland_button_scheduler

Overview:
Shares one debounce lockout counter among NUM_BUTTONS raw button inputs. It synchronizes each input, latches rising edges as pending requests, and grants them one at a time round-robin. Each grant is presented on a valid/ready event port, then a lockout window of COUNT_VALUE cycles follows. Sits between the board buttons and the user-logic consumer, replacing per-button debounce instances.

Parameters:
CLK_FREQUENCY, 10_000_000, clk frequency in Hz
DEBOUNCE_HZ, 2, lockout rate; COUNT_VALUE = CLK_FREQUENCY/DEBOUNCE_HZ (localparam, must be >= 2, elaboration error otherwise)
NUM_BUTTONS, 4, number of button inputs (>= 2)
IDX_W, 2, width of evt_idx; must equal $clog2(NUM_BUTTONS)

Ports:
clk  in  1  clock
reset_n  in  1  reset, asynchronous, active-low
buttons  in  NUM_BUTTONS  raw bouncy button levels, asynchronous to clk
evt_valid  out  1  event available
evt_ready  in  1  consumer accepts event
evt_idx  out  IDX_W  index of granted button; stable while evt_valid
pending  out  NUM_BUTTONS  registered pending-request bits
busy  out  1  high when state != IDLE (combinational from state reg)

Behaviour:
- Reset (async): all sync flops, pending, count, evt_valid, evt_idx = 0; state = IDLE; last_grant = NUM_BUTTONS-1 (button 0 first priority after reset). Reset mid-event drops the event and all pending requests.
- Per button: 2-flop synchronizer s1->s2, plus delay flop s3; edge = s2 & ~s3.
- Pending: set on edge; cleared when granted. Same-cycle set and clear on same bit: clear wins (treated as bounce).
- Lockout mask: while state == LOCKOUT, edges on button evt_idx are ignored; edges on other buttons set pending normally.
- Latency: input rise set up before clock edge 1 -> pending set at edge 3 -> evt_valid high after edge 4 (if IDLE, no competitor).
- FSM (2-bit):
  IDLE: if |pending: pick winner = first set bit searching from last_grant+1 upward, wrapping modulo NUM_BUTTONS; register evt_idx = winner, last_grant = winner, clear pending[winner], evt_valid = 1 -> GRANT. Else stay.
  GRANT: hold evt_valid/evt_idx stable. On evt_valid & evt_ready: evt_valid = 0, count = 0 -> LOCKOUT. No timeout; waits indefinitely.
  LOCKOUT: count += 1 each cycle; when count == COUNT_VALUE-1 -> IDLE. LOCKOUT spans exactly COUNT_VALUE cycles.
  Illegal encoding -> IDLE.
- count width = $clog2(COUNT_VALUE); never exceeds COUNT_VALUE-1, no wrap.
- Back-to-back: next grant earliest one cycle after LOCKOUT exits (IDLE cycle always inserted).
- evt_ready ignored when evt_valid low.

Optional Feature:
YOUSSEFLAND_FIXED_PRIORITY_EN: when defined, the winner is always the lowest-index set pending bit and last_grant is unused. When undefined (default), round-robin as above.

Decomposition:
- Package youssefland_button_pkg: state encodings IDLE=0, GRANT=1, LOCKOUT=2; clog2 helper function.
- Sub-module youssefland_rr_arbiter: combinational, inputs pending and last_grant, outputs winner index and any_req. Contains the fixed-priority `ifdef`.

Test Plan:
(Use CLK_FREQUENCY=16, DEBOUNCE_HZ=2 -> COUNT_VALUE=8, NUM_BUTTONS=4.)
- Reset then buttons[2] rises, evt_ready=1 -> evt_valid high after 4th edge with evt_idx=2; LOCKOUT for 8 cycles; busy low afterwards.
- buttons[1] bounces 1-0-1-0-1 during lockout after its grant -> no further event; pending[1] stays 0.
- buttons[0] and buttons[3] rise same cycle after reset -> grants 0 then 3. Repeat both -> round-robin gives 0 then 3 again (last_grant=3). With YOUSSEFLAND_FIXED_PRIORITY_EN, always 0 first.
- evt_ready held low 20 cycles -> evt_valid and evt_idx stable for all 20; a new edge on another button shows in pending only.
- reset_n asserted during GRANT -> evt_valid=0, pending=0, state IDLE on the same asynchronous edge; no event after release.
- buttons[1] edge during lockout of button 3 -> pending[1]=1; event idx 1 appears 2 cycles after lockout ends (IDLE cycle, then GRANT).

Source files
------------

// File: rtl/youssefland_button_pkg.sv
// Shared types and helpers for the button scheduler slice.
package youssefland_button_pkg;

    // Scheduler FSM states; encoding 3 is illegal and recovers to IDLE.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        LOCKOUT = 2'd2
    } state_t;

    // Ceiling log2, bounded loop so it stays a legal constant function.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned w = 0; w < 32; w++) begin
            if ((64'd1 << w) < 64'(value)) begin
                result = w + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/youssefland_button_scheduler_if.sv
// Valid/ready event port carrying the granted button index.
interface youssefland_button_scheduler_if #(
    parameter int unsigned IDX_W = 2
);
    logic             evt_valid;
    logic             evt_ready;
    logic [IDX_W-1:0] evt_idx;

    modport master (output evt_valid, output evt_idx, input evt_ready);
    modport slave  (input evt_valid, input evt_idx, output evt_ready);
endinterface

// File: rtl/youssefland_rr_arbiter.sv
// Combinational winner selection over pending button requests.
// YOUSSEFLAND_FIXED_PRIORITY_EN: lowest set index always wins, last_grant ignored.
// Default: round-robin search starting one past last_grant, wrapping.
module youssefland_rr_arbiter #(
    parameter int unsigned NUM_BUTTONS = 4,
    parameter int unsigned IDX_W       = 2
) (
    input  logic [NUM_BUTTONS-1:0] pending,
    input  logic [IDX_W-1:0]       last_grant,
    output logic [IDX_W-1:0]       winner,
    output logic                   any_req
);

    assign any_req = |pending;

`ifdef YOUSSEFLAND_FIXED_PRIORITY_EN
    logic unused_last_grant;
    assign unused_last_grant = ^last_grant;

    // Descending scan so the lowest set index is the final assignment.
    always_comb begin
        winner = '0;
        for (int i = int'(NUM_BUTTONS) - 1; i >= 0; i--) begin
            if (pending[IDX_W'(i)]) begin
                winner = IDX_W'(i);
            end
        end
    end
`else
    logic             found;
    logic [IDX_W-1:0] cand;

    // First set bit after last_grant, modulo NUM_BUTTONS.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int unsigned off = 1; off <= NUM_BUTTONS; off++) begin
            cand = IDX_W'((32'(last_grant) + off) % NUM_BUTTONS);
            if (!found && pending[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end
`endif

endmodule

// File: rtl/youssefland_button_scheduler.sv
// Shared-lockout button scheduler: synchronizes raw buttons, latches rising
// edges as pending requests, grants one at a time on a valid/ready port and
// then holds a COUNT_VALUE-cycle lockout before the next grant.
// Optional build macro: YOUSSEFLAND_FIXED_PRIORITY_EN (see arbiter).
module youssefland_button_scheduler
    import youssefland_button_pkg::*;
#(
    parameter int unsigned CLK_FREQUENCY = 10_000_000,
    parameter int unsigned DEBOUNCE_HZ   = 2,
    parameter int unsigned NUM_BUTTONS   = 4,
    parameter int unsigned IDX_W         = 2
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_BUTTONS-1:0]        buttons,
    youssefland_button_scheduler_if.master evt,
    output logic [NUM_BUTTONS-1:0]        pending,
    output logic                          busy
);

    localparam int unsigned COUNT_VALUE = CLK_FREQUENCY / DEBOUNCE_HZ;
    localparam int unsigned CNT_W       = clog2(COUNT_VALUE);

    if (COUNT_VALUE < 2) begin : g_bad_count
        $error("COUNT_VALUE must be at least 2");
    end
    if (NUM_BUTTONS < 2) begin : g_bad_buttons
        $error("NUM_BUTTONS must be at least 2");
    end
    if (IDX_W != clog2(NUM_BUTTONS)) begin : g_bad_idx_w
        $error("IDX_W must equal clog2(NUM_BUTTONS)");
    end

    logic [NUM_BUTTONS-1:0] s1, s2, s3, edges;
    logic [NUM_BUTTONS-1:0] pending_next, grant_clear, lock_mask;
    state_t                 state, state_next;
    logic [CNT_W-1:0]       count, count_next;
    logic                   evt_valid_r, valid_next;
    logic [IDX_W-1:0]       evt_idx_r, idx_next;
    logic [IDX_W-1:0]       last_grant, last_next;
    logic [IDX_W-1:0]       winner;
    logic                   any_req;

    youssefland_rr_arbiter #(
        .NUM_BUTTONS (NUM_BUTTONS),
        .IDX_W       (IDX_W)
    ) u_arb (
        .pending    (pending),
        .last_grant (last_grant),
        .winner     (winner),
        .any_req    (any_req)
    );

    // Two-flop synchronizer plus delay flop for rising-edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= buttons;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign edges = s2 & ~s3;

    // State and registered-output register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            count       <= '0;
            evt_valid_r <= 1'b0;
            evt_idx_r   <= '0;
            last_grant  <= IDX_W'(NUM_BUTTONS - 1);
            pending     <= '0;
        end else begin
            state       <= state_next;
            count       <= count_next;
            evt_valid_r <= valid_next;
            evt_idx_r   <= idx_next;
            last_grant  <= last_next;
            pending     <= pending_next;
        end
    end

    // Next-state, grant, lockout mask and pending update.
    always_comb begin
        state_next  = state;
        count_next  = count;
        valid_next  = evt_valid_r;
        idx_next    = evt_idx_r;
        last_next   = last_grant;
        grant_clear = '0;
        lock_mask   = '0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    idx_next    = winner;
                    last_next   = winner;
                    grant_clear = NUM_BUTTONS'(1) << winner;
                    valid_next  = 1'b1;
                    state_next  = GRANT;
                end
            end
            GRANT: begin
                if (evt_valid_r && evt.evt_ready) begin
                    valid_next = 1'b0;
                    count_next = '0;
                    state_next = LOCKOUT;
                end
            end
            LOCKOUT: begin
                lock_mask = NUM_BUTTONS'(1) << evt_idx_r;
                if (count == CNT_W'(COUNT_VALUE - 1)) begin
                    state_next = IDLE;
                end else begin
                    count_next = count + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                valid_next = 1'b0;
            end
        endcase
        // A grant clear beats a same-cycle edge on that bit.
        pending_next = (pending | (edges & ~lock_mask)) & ~grant_clear;
    end

    assign evt.evt_valid = evt_valid_r;
    assign evt.evt_idx   = evt_idx_r;
    assign busy          = (state != IDLE);

endmodule

// File: tb/tb_youssefland_button_scheduler.sv
// Self-checking bench: vector table, directed corner sequences, random
// stimulus, and a cycle-timestamp reference model checked every cycle.
module tb_youssefland_button_scheduler;

    localparam int unsigned CLK_FREQUENCY = 16;
    localparam int unsigned DEBOUNCE_HZ   = 2;
    localparam int unsigned NUM_BUTTONS   = 4;
    localparam int unsigned IDX_W         = 2;
    localparam int          CV            = 8;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] buttons = 4'b0000;
    logic [3:0] pending;
    logic       busy;

    youssefland_button_scheduler_if #(.IDX_W(IDX_W)) evt_if ();

    youssefland_button_scheduler #(
        .CLK_FREQUENCY (CLK_FREQUENCY),
        .DEBOUNCE_HZ   (DEBOUNCE_HZ),
        .NUM_BUTTONS   (NUM_BUTTONS),
        .IDX_W         (IDX_W)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .buttons (buttons),
        .evt     (evt_if),
        .pending (pending),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [3:0] cap_b   = 4'b0000;
    logic       cap_r   = 1'b0;
    logic       cap_rst = 1'b0;
    logic [3:0] bq [3];
    int         cyc = 0;
    int         acc = -1000;
    bit         m_active = 1'b0;
    int         m_idx = 0;
    int         m_last = 3;
    logic [3:0] m_pend = 4'b0000;
    bit         m_busy = 1'b0;

    function automatic int pick(input logic [3:0] p, input int last);
        int c;
`ifdef YOUSSEFLAND_FIXED_PRIORITY_EN
        for (int i = 0; i < 4; i++) begin
            if (p[i]) return i;
        end
        c = last;
`else
        for (int off = 1; off <= 4; off++) begin
            c = (last + off) % 4;
            if (p[c]) return c;
        end
`endif
        return 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) bq[i] = 4'b0000;
        acc      = -1000;
        m_active = 1'b0;
        m_idx    = 0;
        m_last   = 3;
        m_pend   = 4'b0000;
        m_busy   = 1'b0;
    endtask

    // One clock: edge seen two cycles after a raw rise; lockout is the CV
    // cycles following the accept cycle; grants only when neither granted
    // nor locked.
    task automatic model_step();
        logic [3:0] e, mask, np;
        bit pre_lock, pre_idle;
        int w;
        cyc++;
        e        = bq[1] & ~bq[2];
        pre_lock = (cyc > acc) && (cyc <= acc + CV);
        pre_idle = !m_active && !pre_lock;
        mask     = pre_lock ? (4'b0001 << m_idx) : 4'b0000;
        np       = m_pend | (e & ~mask);
        if (pre_idle && m_pend != 4'b0000) begin
            w        = pick(m_pend, m_last);
            np[w]    = 1'b0;
            m_active = 1'b1;
            m_idx    = w;
            m_last   = w;
        end else if (m_active && cap_r) begin
            m_active = 1'b0;
            acc      = cyc;
        end
        m_pend = np;
        bq[2]  = bq[1];
        bq[1]  = bq[0];
        bq[0]  = cap_b;
        m_busy = m_active || (cyc >= acc && cyc < acc + CV);
    endtask

    always @(posedge clk) begin
        cap_b   = buttons;
        cap_r   = evt_if.evt_ready;
        cap_rst = reset_n;
    end

    always @(negedge clk) begin
        if (!cap_rst) model_reset();
        else          model_step();
        check("sb_valid", int'(evt_if.evt_valid), int'(m_active));
        if (m_active) check("sb_idx", int'(evt_if.evt_idx), m_idx);
        check("sb_pending", int'(pending), int'(m_pend));
        check("sb_busy", int'(busy), int'(m_busy));
    end

    // ---------------- helpers ----------------
    task automatic do_reset();
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        buttons = 4'b0000;
        evt_if.evt_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic wait_valid(input int max_cyc, input string name, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            @(negedge clk);
            if (evt_if.evt_valid) seen = 1'b1;
        end
        check({name, "_seen"}, int'(seen), 1);
    endtask

    task automatic collect(input int window, output int got [$]);
        got = {};
        for (int i = 0; i < window; i++) begin
            @(negedge clk);
            if (evt_if.evt_valid) got.push_back(int'(evt_if.evt_idx));
        end
    endtask

    typedef struct {
        logic [3:0] b;
        logic       r;
        logic       v;
        logic [1:0] idx;
        logic [3:0] p;
        logic       bz;
    } vec_t;

    vec_t tbl [14];

    initial begin
        bit seen;
        bit any_v;
        int got [$];

        evt_if.evt_ready = 1'b0;
        tbl[0] = '{4'b0100, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0};
        tbl[1] = '{4'b0100, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0};
        tbl[2] = '{4'b0100, 1'b1, 1'b0, 2'd0, 4'b0100, 1'b0};
        tbl[3] = '{4'b0100, 1'b1, 1'b1, 2'd2, 4'b0000, 1'b1};
        for (int i = 4; i < 12; i++) tbl[i] = '{4'b0100, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b1};
        tbl[12] = '{4'b0100, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0};
        tbl[13] = '{4'b0100, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0};

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_valid", int'(evt_if.evt_valid), 0);
        check("rst_idx", int'(evt_if.evt_idx), 0);
        check("rst_pending", int'(pending), 0);
        check("rst_busy", int'(busy), 0);
        reset_n = 1'b1;

        // Single grant latency and lockout length.
        for (int i = 0; i < 14; i++) begin
            buttons = tbl[i].b;
            evt_if.evt_ready = tbl[i].r;
            @(negedge clk);
            check($sformatf("vec%0d_valid", i), int'(evt_if.evt_valid), int'(tbl[i].v));
            if (tbl[i].v) check($sformatf("vec%0d_idx", i), int'(evt_if.evt_idx), int'(tbl[i].idx));
            check($sformatf("vec%0d_pending", i), int'(pending), int'(tbl[i].p));
            check($sformatf("vec%0d_busy", i), int'(busy), int'(tbl[i].bz));
        end

        // Bounce on the granted button during its own lockout is masked.
        do_reset();
        evt_if.evt_ready = 1'b1;
        buttons = 4'b0010;
        wait_valid(20, "bounce_grant", seen);
        check("bounce_idx", int'(evt_if.evt_idx), 1);
        @(negedge clk);
        buttons[1] = 1'b0; @(negedge clk);
        buttons[1] = 1'b1; @(negedge clk);
        buttons[1] = 1'b0; @(negedge clk);
        buttons[1] = 1'b1;
        any_v = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (evt_if.evt_valid) any_v = 1'b1;
        end
        check("bounce_no_event", int'(any_v), 0);
        check("bounce_pending1", int'(pending[1]), 0);

        // Simultaneous requests, then repeat for round-robin order.
        do_reset();
        evt_if.evt_ready = 1'b1;
        buttons = 4'b1001;
        collect(40, got);
        check("pair1_count", got.size(), 2);
        if (got.size() >= 2) begin
            check("pair1_first", got[0], 0);
            check("pair1_second", got[1], 3);
        end
        buttons = 4'b0000;
        repeat (12) @(negedge clk);
        buttons = 4'b1001;
        collect(40, got);
        check("pair2_count", got.size(), 2);
        if (got.size() >= 2) begin
            check("pair2_first", got[0], 0);
            check("pair2_second", got[1], 3);
        end

        // Backpressure: event held stable, new edge only shows in pending.
        do_reset();
        buttons = 4'b0100;
        wait_valid(20, "hold_grant", seen);
        for (int i = 0; i < 20; i++) begin
            if (i == 5) buttons = 4'b0101;
            @(negedge clk);
            check($sformatf("hold%0d_valid", i), int'(evt_if.evt_valid), 1);
            check($sformatf("hold%0d_idx", i), int'(evt_if.evt_idx), 2);
        end
        check("hold_pending", int'(pending), 4'b0001);
        evt_if.evt_ready = 1'b1;
        @(negedge clk);
        check("hold_accept", int'(evt_if.evt_valid), 0);
        wait_valid(30, "hold_next", seen);
        check("hold_next_idx", int'(evt_if.evt_idx), 0);

        // Asynchronous reset during GRANT drops everything immediately.
        do_reset();
        buttons = 4'b1010;
        wait_valid(20, "arst_grant", seen);
        check("arst_idx", int'(evt_if.evt_idx), 1);
        check("arst_pend_before", int'(pending), 4'b1000);
        #2;
        reset_n = 1'b0;
        buttons = 4'b0000;
        #1;
        check("arst_valid", int'(evt_if.evt_valid), 0);
        check("arst_pending", int'(pending), 0);
        check("arst_busy", int'(busy), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        evt_if.evt_ready = 1'b1;
        any_v = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (evt_if.evt_valid) any_v = 1'b1;
        end
        check("arst_no_event", int'(any_v), 0);

        // Other button's edge during lockout: grant right after the IDLE cycle.
        do_reset();
        evt_if.evt_ready = 1'b1;
        buttons = 4'b1000;
        wait_valid(20, "lock_grant", seen);
        check("lock_idx", int'(evt_if.evt_idx), 3);
        @(negedge clk);
        buttons = 4'b1010;
        for (int n = 1; n <= 9; n++) begin
            @(negedge clk);
            if (n == 4) check("lock_pending1", int'(pending), 4'b0010);
            if (n == 8) begin
                check("lock_exit_busy", int'(busy), 0);
                check("lock_exit_valid", int'(evt_if.evt_valid), 0);
            end
            if (n == 9) begin
                check("lock_next_valid", int'(evt_if.evt_valid), 1);
                check("lock_next_idx", int'(evt_if.evt_idx), 1);
            end
        end

        // Random buttons and ready against the model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 5) == 0) buttons[b] = ~buttons[b];
            end
            evt_if.evt_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
